// File: rtl/icache_responder_if.sv
// Fetch-side request/response and burst fill signals of the instruction cache.
// slave = the cache's view, master = the fetch stage / memory system view.
interface icache_responder_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic        bmem_rvalid;
    logic [63:0] bmem_rdata;

    modport slave (
        input  imem_addr, imem_rmask, bmem_ready, bmem_rvalid, bmem_rdata,
        output imem_rdata, imem_resp, bmem_addr, bmem_read
    );

    modport master (
        output imem_addr, imem_rmask, bmem_ready, bmem_rvalid, bmem_rdata,
        input  imem_rdata, imem_resp, bmem_addr, bmem_read
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache (32-byte lines, 4x64-bit burst fills).
// Define ICACHE_PERF_CNT_EN to add saturating hit_count / miss_count outputs.
module icache_responder #(
    parameter int NUM_SETS = 16
) (
    input  logic               clk,
    input  logic               rst,
    icache_responder_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, RESP} state_t;

    state_t                 state_q, state_d;
    logic [31:2]            addr_q, addr_d;
    logic [31:0]            bmem_addr_q, bmem_addr_d;
    logic [1:0]             beat_q, beat_d;
    logic [3:0][63:0]       line_buf_q, line_buf_d;
    logic [NUM_SETS-1:0]    valid_q, valid_d;

    logic [255:0]           data_mem [NUM_SETS];
    logic [TAG_W-1:0]       tag_mem  [NUM_SETS];
    logic [255:0]           rd_line_q, rd_line_d;
    logic [TAG_W-1:0]       rd_tag_q, rd_tag_d;

    logic [IDX_W-1:0]       rd_idx;
    logic [IDX_W-1:0]       lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   hit;
    logic                   mem_we;
    logic                   resp;
    logic [31:0]            rdata;
    logic [7:0][31:0]       rd_words;
    logic [7:0][31:0]       fill_words;

    assign rd_idx = bus.imem_addr[5 +: IDX_W];
    assign lk_idx = addr_q[5 +: IDX_W];
    assign lk_tag = addr_q[31 -: TAG_W];
    assign hit    = valid_q[lk_idx] && (rd_tag_q == lk_tag);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_words
            assign rd_words[gi]   = rd_line_q[gi*32 +: 32];
            assign fill_words[gi] = line_buf_q[gi/2][(gi%2)*32 +: 32];
        end
    endgenerate

    // Arrays are read every cycle at the incoming address, so on the accept
    // edge the set for the just-latched request lands in rd_line_q/rd_tag_q.
    always_comb begin
        rd_line_d = data_mem[rd_idx];
        rd_tag_d  = tag_mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[lk_idx] <= line_buf_d;
            tag_mem[lk_idx]  <= lk_tag;
        end
        rd_line_q <= rd_line_d;
        rd_tag_q  <= rd_tag_d;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bmem_addr_d = bmem_addr_q;
        beat_d      = beat_q;
        line_buf_d  = line_buf_q;
        valid_d     = valid_q;
        mem_we      = 1'b0;
        resp        = 1'b0;
        rdata       = 32'h0;
        case (state_q)
            IDLE: begin
                if (|bus.imem_rmask) begin
                    addr_d  = bus.imem_addr[31:2];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp    = 1'b1;
                    rdata   = rd_words[addr_q[4:2]];
                    state_d = IDLE;
                end else begin
                    bmem_addr_d = {addr_q[31:5], 5'b0};
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus.bmem_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.bmem_rvalid) begin
                    line_buf_d[beat_q] = bus.bmem_rdata;
                    beat_d             = beat_q + 2'd1;
                    // Last beat: commit the assembled line, including this beat.
                    if (beat_q == 2'd3) begin
                        mem_we          = 1'b1;
                        valid_d[lk_idx] = 1'b1;
                        state_d         = RESP;
                    end
                end
            end
            RESP: begin
                resp    = 1'b1;
                rdata   = fill_words[addr_q[4:2]];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bmem_addr_q <= '0;
            beat_q      <= '0;
            line_buf_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bmem_addr_q <= bmem_addr_d;
            beat_q      <= beat_d;
            line_buf_q  <= line_buf_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.imem_resp  = resp;
    assign bus.imem_rdata = rdata;
    assign bus.bmem_read  = (state_q == REQ);
    assign bus.bmem_addr  = bmem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_responder.sv
// Directed scoreboard bench for icache_responder: misses, hits, eviction,
// hold-after-response, reset during a fill and address changes while pending.
module tb_icache_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_responder_if bus();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_responder #(.NUM_SETS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int resp_count = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb [$];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.bmem_read && bus.bmem_ready) hs_count++;
            if (bus.imem_resp) resp_count++;
        end
    end

    // Line 0x1000_0000 carries the fixed beat pattern; every other line
    // holds its own byte address in each word.
    function automatic logic [63:0] beat_of(input logic [31:0] line, input int k);
        logic [31:0] lo;
        if (line == 32'h1000_0000) begin
            case (k)
                0:       return 64'h1111_1111_0000_0000;
                1:       return 64'h3333_3333_2222_2222;
                2:       return 64'h5555_5555_5555_5555;
                default: return 64'h7777_7777_7777_7777;
            endcase
        end
        lo = line + 32'(8 * k);
        return {lo + 32'd4, lo};
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        logic [63:0] b;
        b = beat_of({addr[31:5], 5'b0}, int'(addr[4:3]));
        return addr[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string tag);
        logic [31:0] exp;
        check({tag, " resp"}, 64'(bus.imem_resp), 64'd1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, " rdata"}, 64'(bus.imem_rdata), 64'(exp));
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] addr, input bit exp_miss,
                           input int ready_dly, input logic [31:0] swap_addr, input bit hold);
        int hs0;
        int n;
        logic [31:0] line;
        line = {addr[31:5], 5'b0};
        hs0  = hs_count;
        bus.imem_addr  = addr;
        bus.imem_rmask = 4'hF;
        sb.push_back(word_of(addr));
        tick();
        if (exp_miss) begin
            exp_misses++;
            check({tag, " lookup_no_resp"}, 64'(bus.imem_resp), 64'd0);
            check({tag, " lookup_rdata_zero"}, 64'(bus.imem_rdata), 64'd0);
            n = 0;
            while (!bus.bmem_read && n < 8) begin
                tick();
                n++;
            end
            check({tag, " bmem_read"}, 64'(bus.bmem_read), 64'd1);
            check({tag, " bmem_addr"}, 64'(bus.bmem_addr), 64'(line));
            if (swap_addr != 32'h0) bus.imem_addr = swap_addr;
            repeat (ready_dly) begin
                tick();
                check({tag, " read_held"}, 64'(bus.bmem_read), 64'd1);
            end
            check({tag, " bmem_addr_stable"}, 64'(bus.bmem_addr), 64'(line));
            bus.bmem_ready = 1'b1;
            tick();
            bus.bmem_ready = 1'b0;
            check({tag, " read_dropped"}, 64'(bus.bmem_read), 64'd0);
            for (int k = 0; k < 4; k++) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata  = beat_of(line, k);
                tick();
            end
            bus.bmem_rvalid = 1'b0;
            bus.bmem_rdata  = 64'h0;
        end else begin
            exp_hits++;
        end
        $display("req %s addr=%h resp=%0d rdata=%h", tag, addr, bus.imem_resp, bus.imem_rdata);
        expect_resp(tag);
        check({tag, " handshakes"}, 64'(hs_count - hs0), exp_miss ? 64'd1 : 64'd0);
        if (!hold) bus.imem_rmask = 4'h0;
        tick();
        bus.imem_rmask = 4'h0;
        check({tag, " resp_single"}, 64'(bus.imem_resp), 64'd0);
    endtask

    initial begin
        int rc0;
        int hs0;
        bus.imem_addr   = 32'h0;
        bus.imem_rmask  = 4'h0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = 64'h0;

        repeat (3) tick();
        check("reset resp", 64'(bus.imem_resp), 64'd0);
        check("reset rdata", 64'(bus.imem_rdata), 64'd0);
        check("reset bmem_read", 64'(bus.bmem_read), 64'd0);
        check("reset bmem_addr", 64'(bus.bmem_addr), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle resp", 64'(bus.imem_resp), 64'd0);
            check("idle rdata", 64'(bus.imem_rdata), 64'd0);
            check("idle bmem_read", 64'(bus.bmem_read), 64'd0);
        end

        run_req("cold_miss", 32'h1000_0004, 1'b1, 2, 32'h0, 1'b0);
        run_req("hit_word6", 32'h1000_0018, 1'b0, 0, 32'h0, 1'b0);

        run_req("hold_hit", 32'h1000_0008, 1'b0, 0, 32'h0, 1'b1);
        rc0 = resp_count;
        hs0 = hs_count;
        repeat (4) tick();
        check("hold no_second_resp", 64'(resp_count - rc0), 64'd0);
        check("hold no_fill", 64'(hs_count - hs0), 64'd0);

        run_req("evict_new", 32'h1000_0200, 1'b1, 0, 32'h0, 1'b0);
        run_req("evict_refetch", 32'h1000_0004, 1'b1, 1, 32'h0, 1'b0);

        run_req("addr_swap", 32'h1000_0314, 1'b1, 1, 32'h2000_0000, 1'b0);
        run_req("addr_swap_hit", 32'h1000_0310, 1'b0, 0, 32'h0, 1'b0);

        // Abort a fill of line 0x1000_0040 after two beats.
        bus.imem_addr  = 32'h1000_0040;
        bus.imem_rmask = 4'hF;
        tick();
        tick();
        check("abort bmem_read", 64'(bus.bmem_read), 64'd1);
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = beat_of(32'h1000_0040, k);
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        bus.imem_rmask  = 4'h0;
        rst = 1'b1;
        #1;
        check("abort resp", 64'(bus.imem_resp), 64'd0);
        check("abort rdata", 64'(bus.imem_rdata), 64'd0);
        check("abort bmem_read", 64'(bus.bmem_read), 64'd0);
        check("abort bmem_addr", 64'(bus.bmem_addr), 64'd0);
        exp_hits   = 0;
        exp_misses = 0;
        tick();
        rst = 1'b0;
        rc0 = resp_count;
        for (int k = 2; k < 4; k++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = beat_of(32'h1000_0040, k);
            tick();
            check("stray resp", 64'(bus.imem_resp), 64'd0);
            check("stray bmem_read", 64'(bus.bmem_read), 64'd0);
        end
        bus.bmem_rvalid = 1'b0;
        tick();
        check("stray no_resp_total", 64'(resp_count - rc0), 64'd0);

        run_req("after_rst_same", 32'h1000_0040, 1'b1, 0, 32'h0, 1'b0);
        run_req("after_rst_old", 32'h1000_0008, 1'b1, 0, 32'h0, 1'b0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
`ifdef ICACHE_PERF_CNT_EN
        check("perf hits", 64'(hit_count), 64'(exp_hits));
        check("perf misses", 64'(miss_count), 64'(exp_misses));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
